// File: rtl/oec_pkg.sv
// Shared definitions for the over-exposure-correction pipeline controller and its datapath.
package oec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Enable-to-aligned-output latency of the imoy/m, tanh and delay-line datapath.
  localparam int OEC_LAT = 25;

  localparam int TAG_VLD = 3;
  localparam int TAG_SOF = 2;
  localparam int TAG_EOL = 1;
  localparam int TAG_EOF = 0;

  typedef struct packed {
    logic vld;
    logic sof;
    logic eol;
    logic eof;
  } tag_t;

endpackage

// File: rtl/oec_tag_pipe.sv
// Fixed-latency sideband shift register; the datapath never stalls, so this shifts every cycle.
module oec_tag_pipe
  import oec_pkg::*;
#(
  parameter int LAT = OEC_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t [LAT-1:0] r_stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
    end else if (i_clr) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < LAT; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[LAT-1];

endmodule

// File: rtl/oec_pipe_ctrl.sv
// Frame sequencer for the OEC pixel pipeline: raster tagging, credit throttling, drain and abort.
// Optional stall counter port perf_stall is built only when OEC_PIPE_CTRL_PERF_EN is defined.
module oec_pipe_ctrl
  import oec_pkg::*;
#(
  parameter int LAT        = OEC_LAT,
  parameter int FIFO_DEPTH = 32,
  parameter int CW         = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cfg_width,
  input  logic [CW-1:0] cfg_height,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          dp_en,
  input  logic          fifo_pop,
  output logic          tag_vld,
  output logic          tag_sof,
  output logic          tag_eol,
  output logic          tag_eof,
  output logic          fifo_flush,
  output logic          busy,
  output logic          done
`ifdef OEC_PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_stall
`endif
);

  localparam int CRW = $clog2(FIFO_DEPTH + 1);
  localparam int IFW = $clog2(LAT + 1);

  state_t         r_state;
  logic [CW-1:0]  r_cfg_w, r_cfg_h, r_col, r_row;
  logic [CRW-1:0] r_credit;
  logic [IFW-1:0] r_inflight;
  logic           r_flush, r_done, r_busy;

  logic           w_accept, w_pop, w_sof, w_eol, w_eof;
  logic [IFW-1:0] w_inflight_nxt;
  tag_t           w_tag_in, w_tag_out;

  assign in_ready = (r_state == ST_RUN) && (r_credit < CRW'(FIFO_DEPTH));
  assign w_accept = in_valid && in_ready;
  assign dp_en    = w_accept;
  // Pops against an empty credit pool are dropped so the counter cannot wrap.
  assign w_pop    = fifo_pop && (r_credit != '0);

  assign w_sof = (r_row == '0) && (r_col == '0);
  assign w_eol = (r_col == r_cfg_w - CW'(1));
  assign w_eof = w_eol && (r_row == r_cfg_h - CW'(1));

  assign w_tag_in = {w_accept, w_accept && w_sof, w_accept && w_eol, w_accept && w_eof};

  oec_tag_pipe #(.LAT(LAT)) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_clr (abort),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign tag_vld    = w_tag_out.vld;
  assign tag_sof    = w_tag_out.sof;
  assign tag_eol    = w_tag_out.eol;
  assign tag_eof    = w_tag_out.eof;
  assign fifo_flush = r_flush;
  assign busy       = r_busy;
  assign done       = r_done;

  always_comb begin
    w_inflight_nxt = r_inflight;
    case ({w_accept, tag_vld})
      2'b10:   w_inflight_nxt = r_inflight + IFW'(1);
      2'b01:   w_inflight_nxt = r_inflight - IFW'(1);
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit   <= '0;
      r_inflight <= '0;
    end else if (abort) begin
      r_credit   <= '0;
      r_inflight <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      case ({w_accept, w_pop})
        2'b10:   r_credit <= r_credit + CRW'(1);
        2'b01:   r_credit <= r_credit - CRW'(1);
        default: r_credit <= r_credit;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cfg_w <= '0;
      r_cfg_h <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_flush <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_flush <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cfg_w <= cfg_width;
            r_cfg_h <= cfg_height;
            r_col   <= '0;
            r_row   <= '0;
            r_busy  <= 1'b1;
            if ((cfg_width == '0) || (cfg_height == '0)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (w_eol) begin
              r_col <= '0;
              r_row <= r_row + CW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
            if (w_eof) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Leave as soon as the last token exits so done follows the final tag by one cycle.
          if (w_inflight_nxt == '0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef OEC_PIPE_CTRL_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf <= '0;
    end else if ((r_state == ST_IDLE) && start && !abort) begin
      r_perf <= '0;
    end else if ((r_state == ST_RUN) && in_valid && !in_ready && (r_perf != '1)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_stall = r_perf;
`endif

endmodule

// File: tb/tb_oec_pipe_ctrl.sv
// Bench for oec_pipe_ctrl: directed frame scenarios plus random traffic against a tag-schedule model.
module tb_oec_pipe_ctrl;

  localparam int LAT   = 25;
  localparam int DEPTH = 32;
  localparam int CW    = 12;
  localparam int TSZ   = 8192;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] cfg_width = '0, cfg_height = '0;
  logic          start = 1'b0, abort = 1'b0, in_valid = 1'b0, fifo_pop = 1'b0;
  logic          in_ready, dp_en, tag_vld, tag_sof, tag_eol, tag_eof;
  logic          fifo_flush, busy, done;
`ifdef OEC_PIPE_CTRL_PERF_EN
  logic [31:0]   perf_stall;
`endif

  oec_pipe_ctrl #(.LAT(LAT), .FIFO_DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dp_en      (dp_en),
    .fifo_pop   (fifo_pop),
    .tag_vld    (tag_vld),
    .tag_sof    (tag_sof),
    .tag_eol    (tag_eol),
    .tag_eof    (tag_eof),
    .fifo_flush (fifo_flush),
    .busy       (busy),
    .done       (done)
`ifdef OEC_PIPE_CTRL_PERF_EN
    ,
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  // Reference model: frame phase, credit pool, window index and a cycle-indexed schedule of tags.
  int          c = 0;
  int          m_phase = M_IDLE, m_credit = 0, m_w = 0, m_h = 0, m_k = 0;
  bit          m_flush = 1'b0;
  bit [31:0]   m_perf = '0;
  bit [3:0]    exp_tag [TSZ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, c);
  endtask

  task automatic cyc(input bit v, input bit p, input bit s, input bit a);
    bit       e_ready, e_acc, pop_eff, pend;
    bit [3:0] e_tag;
    in_valid = v; fifo_pop = p; start = s; abort = a;
    @(negedge clk);
    e_ready = (m_phase == M_RUN) && (m_credit < DEPTH);
    e_acc   = e_ready && v;
    e_tag   = exp_tag[c % TSZ];
    chk("busy", busy, m_phase != M_IDLE);
    chk("done", done, m_phase == M_DONE);
    chk("in_ready", in_ready, e_ready);
    chk("dp_en", dp_en, e_acc);
    chk("tags", {tag_vld, tag_sof, tag_eol, tag_eof}, e_tag);
    chk("fifo_flush", fifo_flush, m_flush);
`ifdef OEC_PIPE_CTRL_PERF_EN
    chk("perf_stall", perf_stall, m_perf);
`endif
    exp_tag[c % TSZ] = '0;
    if (m_phase == M_IDLE && s && !a) m_perf = '0;
    else if (m_phase == M_RUN && v && !e_ready && m_perf != 32'hFFFF_FFFF) m_perf++;
    if (a) begin
      m_phase = M_IDLE; m_credit = 0; m_flush = 1'b1;
      for (int i = 1; i <= LAT; i++) exp_tag[(c + i) % TSZ] = '0;
    end else begin
      m_flush = 1'b0;
      pop_eff = p && (m_credit > 0);
      m_credit = m_credit + int'(e_acc) - int'(pop_eff);
      if (e_acc) begin
        exp_tag[(c + LAT) % TSZ] = {1'b1, m_k == 0, (m_k % m_w) == m_w - 1, m_k == m_w * m_h - 1};
        m_k++;
      end
      case (m_phase)
        M_IDLE: if (s) begin
          m_w = int'(cfg_width); m_h = int'(cfg_height); m_k = 0;
          m_phase = (m_w == 0 || m_h == 0) ? M_DONE : M_RUN;
        end
        M_RUN: if (m_k == m_w * m_h) m_phase = M_DRAIN;
        M_DRAIN: begin
          pend = 1'b0;
          for (int i = 1; i <= LAT; i++) if (exp_tag[(c + i) % TSZ] != '0) pend = 1'b1;
          if (!pend) m_phase = M_DONE;
        end
        default: m_phase = M_IDLE;
      endcase
    end
    @(posedge clk); #1;
    c++;
  endtask

  task automatic start_frame(input int w, input int h, input bit v, input bit p);
    cfg_width = CW'(w); cfg_height = CW'(h);
    cyc(v, p, 1'b1, 1'b0);
  endtask

  task automatic run_frame(input int vp, input int pp, input int budget);
    for (int i = 0; i < budget && m_phase != M_IDLE; i++)
      cyc($urandom_range(99) < vp, $urandom_range(99) < pp, 1'b0, 1'b0);
    chk("frame_finished", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < TSZ; i++) exp_tag[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_tags", {tag_vld, tag_sof, tag_eol, tag_eof}, 4'h0);
    chk("rst_flush", fifo_flush, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) cyc(0, 0, 0, 0);

    // 4x2 frame, valid and pop held high
    start_frame(4, 2, 1, 1);
    run_frame(100, 100, 200);
    repeat (4) cyc(0, 1, 0, 0);

    // 8x8 frame with no pops: 32 accepts then stall, then one pop every third cycle
    start_frame(8, 8, 1, 0);
    repeat (39) cyc(1, 0, 0, 0);
    chk("credit_full_ready", in_ready, 1'b0);
`ifdef OEC_PIPE_CTRL_PERF_EN
    chk("perf_seven", perf_stall, 32'd7);
`endif
    for (int i = 0; i < 600 && m_phase != M_IDLE; i++) cyc(1, (i % 3) == 0, 0, 0);
    chk("slow_frame_finished", busy, 1'b0);
    repeat (40) cyc(0, 1, 0, 0);

    // accept and pop together at credit 31
    start_frame(40, 1, 1, 0);
    repeat (31) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("cr31_ready", in_ready, 1'b1);
    run_frame(100, 100, 400);
    repeat (40) cyc(0, 1, 0, 0);

    // abort with tokens in flight
    start_frame(16, 4, 1, 1);
    repeat (10) cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_flush", fifo_flush, 1'b1);
    repeat (LAT + 5) cyc(1, 1, 0, 0);

    // abort beats a coincident start in IDLE
    cfg_width = 12'd3; cfg_height = 12'd3;
    cyc(0, 0, 1, 1);
    chk("start_abort_busy", busy, 1'b0);
    chk("start_abort_flush", fifo_flush, 1'b1);
    repeat (3) cyc(0, 0, 0, 0);

    // zero width: straight to DONE
    start_frame(0, 3, 1, 1);
    chk("cfg0_done", done, 1'b1);
    repeat (5) cyc(1, 1, 0, 0);

    // single-window frame
    start_frame(1, 1, 1, 1);
    run_frame(100, 100, 100);
    repeat (3) cyc(0, 1, 0, 0);

    // random frames with gaps, stray starts and rare aborts
    for (int f = 0; f < 8; f++) begin
      start_frame($urandom_range(6, 1), $urandom_range(4, 1), 1'($urandom_range(1)), 1'($urandom_range(1)));
      for (int i = 0; i < 1500 && m_phase != M_IDLE; i++)
        cyc($urandom_range(99) < 70, $urandom_range(99) < 60,
            $urandom_range(19) == 0, $urandom_range(149) == 0);
      chk("rand_frame_finished", busy, 1'b0);
      repeat ($urandom_range(4)) cyc(0, 1, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
